// File: rtl/bpf_pkg.sv
// Shared definitions for the BPF-style ALU sequencer: op codes, states, instruction fields.
// Latency: none (constants and a pure helper function only).
// Backpressure: not applicable.
package bpf_pkg;

   // Instruction word layout
   localparam int INSN_W  = 16;
   localparam int OPC_HI  = 15;
   localparam int OPC_LO  = 12;
   localparam int SRC_BIT = 11;
   localparam int RSV_HI  = 10;
   localparam int RSV_LO  = 8;
   localparam int IMM_HI  = 7;
   localparam int IMM_LO  = 0;

   // ALU op codes, identical to the ALU's own encoding
   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_MUL = 4'd3;
   localparam logic [3:0] OP_DIV = 4'd4;
   localparam logic [3:0] OP_AND = 4'd5;
   localparam logic [3:0] OP_OR  = 4'd6;
   localparam logic [3:0] OP_NOT = 4'd7;

   // Sequencer-only op codes; 11..15 behave as NOP
   localparam logic [3:0] OPC_LDA  = 4'd8;
   localparam logic [3:0] OPC_TAX  = 4'd9;
   localparam logic [3:0] OPC_EMIT = 4'd10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      EMIT = 2'd2
   } seq_state_t;

   // True for op codes that are forwarded to the ALU
   function automatic logic is_alu_opc(input logic [3:0] opc);
      return (opc >= OP_ADD) && (opc <= OP_NOT);
   endfunction

endpackage

// File: rtl/bpf_insn_dec.sv
// Combinational instruction decoder: splits a 16-bit instruction into class flags and fields.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the sequencer decides when the decode is consumed.
module bpf_insn_dec
   import bpf_pkg::*;
(
   input  logic [INSN_W-1:0] in_insn,
   output logic              is_alu,
   output logic              is_lda,
   output logic              is_tax,
   output logic              is_emit,
   output logic [3:0]        alu_op,
   output logic              use_x,
   output logic [7:0]        imm
);

   logic [3:0] w_opc;
   logic       w_unused_rsvd;

   assign w_opc         = in_insn[OPC_HI:OPC_LO];
   // Reserved bits carry no meaning; they are deliberately ignored
   assign w_unused_rsvd = ^in_insn[RSV_HI:RSV_LO];

   // Classify the op code and pass the operand fields through
   always_comb begin
      is_alu  = is_alu_opc(w_opc);
      is_lda  = (w_opc == OPC_LDA);
      is_tax  = (w_opc == OPC_TAX);
      is_emit = (w_opc == OPC_EMIT);
      alu_op  = is_alu_opc(w_opc) ? w_opc : OP_NOP;
      use_x   = in_insn[SRC_BIT];
      imm     = in_insn[IMM_HI:IMM_LO];
   end

endmodule

// File: rtl/bpf_alu_seq.sv
// Instruction sequencer driving an external combinational ALU; holds accumulator A and index X.
// Latency: ALU insn 2 cycles (accept, execute), LDA/TAX/NOP 1 cycle, EMIT >= 2 cycles.
// Backpressure: in_ready is low outside IDLE; EMIT holds out_data until out_ready.
// Optional build macro BPF_ALU_SEQ_DIV0_CHK_EN: suppress write-back on divide by zero and raise err_div0.
module bpf_alu_seq
   import bpf_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int OP_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INSN_W-1:0] in_insn,
   output logic [DATA_W-1:0] alu_i1,
   output logic [DATA_W-1:0] alu_i2,
   output logic [OP_W-1:0]   alu_op,
   input  logic [DATA_W-1:0] alu_o,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              err_div0
);

   seq_state_t        r_state;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_x;
   logic              r_in_ready;
   logic [DATA_W-1:0] r_alu_i1;
   logic [DATA_W-1:0] r_alu_i2;
   logic [OP_W-1:0]   r_alu_op;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;

   logic              w_is_alu;
   logic              w_is_lda;
   logic              w_is_tax;
   logic              w_is_emit;
   logic [3:0]        w_op;
   logic              w_use_x;
   logic [7:0]        w_imm;
   logic [DATA_W-1:0] w_src;

   bpf_insn_dec u_dec (
      .in_insn (in_insn),
      .is_alu  (w_is_alu),
      .is_lda  (w_is_lda),
      .is_tax  (w_is_tax),
      .is_emit (w_is_emit),
      .alu_op  (w_op),
      .use_x   (w_use_x),
      .imm     (w_imm)
   );

   // Second operand as selected by the src bit of the incoming instruction
   assign w_src = w_use_x ? r_x : DATA_W'(w_imm);

`ifdef BPF_ALU_SEQ_DIV0_CHK_EN
   logic r_err_div0;
   logic w_div0;

   // Divide by zero is detected on the operands actually presented to the ALU
   assign w_div0   = (r_alu_op == OP_W'(OP_DIV)) && (r_alu_i2 == '0);
   assign err_div0 = r_err_div0;

   // Sticky error flag, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_err_div0 <= 1'b0;
      else if ((r_state == EXEC) && w_div0)
         r_err_div0 <= 1'b1;
   end
`else
   assign err_div0 = 1'b0;
`endif

   // Main FSM: accept, execute, emit; every output comes from a register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_x         <= '0;
         r_in_ready  <= 1'b1;
         r_alu_i1    <= '0;
         r_alu_i2    <= '0;
         r_alu_op    <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  if (w_is_alu) begin
                     // A cannot change before EXEC, so it is safe to capture it now
                     r_state    <= EXEC;
                     r_in_ready <= 1'b0;
                     r_alu_op   <= OP_W'(w_op);
                     r_alu_i1   <= r_a;
                     r_alu_i2   <= w_src;
                  end else if (w_is_emit) begin
                     r_state     <= EMIT;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_out_data  <= r_a;
                  end else if (w_is_lda) begin
                     r_a <= w_src;
                  end else if (w_is_tax) begin
                     r_x <= r_a;
                  end
               end
            end
            EXEC: begin
`ifdef BPF_ALU_SEQ_DIV0_CHK_EN
               if (!w_div0)
                  r_a <= alu_o;
`else
               r_a <= alu_o;
`endif
               // Return the ALU to its quiescent all-zero inputs
               r_alu_op   <= '0;
               r_alu_i1   <= '0;
               r_alu_i2   <= '0;
               r_in_ready <= 1'b1;
               r_state    <= IDLE;
            end
            EMIT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_out_data  <= '0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign alu_op    = r_alu_op;
   assign alu_i1    = r_alu_i1;
   assign alu_i2    = r_alu_i2;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

endmodule

// File: tb/tb_bpf_alu_seq.sv
// Directed bench for bpf_alu_seq with a behavioural 8-bit ALU attached to the alu_* port.
// Latency: checks the 2-cycle ALU path, 1-cycle LDA/TAX and held EMIT handshake.
// Backpressure: exercises out_ready low for several cycles and async reset during EMIT.
module tb_bpf_alu_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_insn = 16'h0000;
   logic [7:0]  alu_i1;
   logic [7:0]  alu_i2;
   logic [3:0]  alu_op;
   logic [7:0]  alu_o;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_data;
   logic        err_div0;

   int checks   = 0;
   int failures = 0;
   int alu_busy = 0;

   bpf_alu_seq #(.DATA_W(8), .OP_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_insn   (in_insn),
      .alu_i1    (alu_i1),
      .alu_i2    (alu_i2),
      .alu_op    (alu_op),
      .alu_o     (alu_o),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .err_div0  (err_div0)
   );

   always #5 clk = ~clk;

   // Behavioural ALU; divide by zero returns all ones
   always_comb begin
      alu_o = 8'h00;
      case (alu_op)
         4'd1: alu_o = alu_i1 + alu_i2;
         4'd2: alu_o = alu_i1 - alu_i2;
         4'd3: alu_o = 8'(alu_i1 * alu_i2);
         4'd4: alu_o = (alu_i2 == 8'h00) ? 8'hFF : alu_i1 / alu_i2;
         4'd5: alu_o = alu_i1 & alu_i2;
         4'd6: alu_o = alu_i1 | alu_i2;
         4'd7: alu_o = ~alu_i1;
         default: alu_o = 8'h00;
      endcase
   end

   // Count cycles during which the ALU is being driven
   always @(negedge clk) if (alu_op != 4'd0) alu_busy++;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one instruction at a negedge once in_ready is seen; returns 1ns after the accept edge
   task automatic issue(input logic [15:0] insn);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("issue_timeout", 8'(in_ready), 8'h01);
      in_valid = 1'b1;
      in_insn  = insn;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // EMIT with out_ready high: one valid cycle carrying exp, then back to IDLE
   task automatic emit_chk(input string tag, input logic [7:0] exp);
      out_ready = 1'b1;
      issue(16'hA000);
      @(negedge clk);
      chk({tag, "_vld"}, 8'(out_valid), 8'h01);
      chk({tag, "_dat"}, out_data, exp);
      @(negedge clk);
      chk({tag, "_done"}, 8'(out_valid), 8'h00);
      chk({tag, "_rdy"}, 8'(in_ready), 8'h01);
   endtask

   logic [15:0] prog [5];
   int          idx;
   int          low_cnt;
   int          busy0;
   logic [7:0]  div0_exp;

   initial begin
      // Reset
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 8'(in_ready), 8'h01);
      chk("rst_out_valid", 8'(out_valid), 8'h00);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_alu_op", 8'(alu_op), 8'h00);
      chk("rst_alu_i1", alu_i1, 8'h00);
      chk("rst_alu_i2", alu_i2, 8'h00);
      chk("rst_err", 8'(err_div0), 8'h00);
      rst_n = 1'b1;

      // LDA 5, ADD 3, EMIT -> 8; ALU busy exactly one cycle
      busy0 = alu_busy;
      issue(16'h8005);
      issue(16'h1003);
      chk("add_op", 8'(alu_op), 8'h01);
      chk("add_i1", alu_i1, 8'h05);
      chk("add_i2", alu_i2, 8'h03);
      chk("add_rdy_low", 8'(in_ready), 8'h00);
      emit_chk("add", 8'h08);
      chk("add_busy_cycles", 8'(alu_busy - busy0), 8'h01);

      // Wrap-around add and truncated multiply
      issue(16'h80FF);
      issue(16'h1001);
      emit_chk("wrap", 8'h00);
      chk("wrap_err", 8'(err_div0), 8'h00);
      issue(16'h8010);
      issue(16'h3020);
      emit_chk("mul", 8'h00);

      // SUB, NOT, OR, AND; opcode 12 is a NOP
      issue(16'h8030);
      issue(16'h2011);
      emit_chk("sub", 8'h1F);
      issue(16'h7055);
      emit_chk("not", 8'hE0);
      issue(16'h600F);
      issue(16'h503C);
      issue(16'hC0AA);
      emit_chk("or_and_nop", 8'h2C);

      // Back-to-back stream: LDA 7, TAX, LDA 0x2A, DIV X, EMIT -> 6
      prog[0] = 16'h8007; prog[1] = 16'h9000; prog[2] = 16'h802A;
      prog[3] = 16'h4800; prog[4] = 16'hA000;
      idx = 0; low_cnt = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 20 && idx < 5; c++) begin
         @(negedge clk);
         if (in_ready) begin
            in_valid = 1'b1;
            in_insn  = prog[idx];
            idx++;
         end else begin
            low_cnt++;
         end
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("b2b_issued", 8'(idx), 8'h05);
      chk("b2b_ready_low", 8'(low_cnt), 8'h01);
      @(negedge clk);
      chk("div_vld", 8'(out_valid), 8'h01);
      chk("div_dat", out_data, 8'h06);
      @(negedge clk);
      chk("div_done", 8'(out_valid), 8'h00);

      // EMIT held for 5 cycles by out_ready low
      out_ready = 1'b0;
      issue(16'hA000);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("hold_vld", 8'(out_valid), 8'h01);
         chk("hold_dat", out_data, 8'h06);
         chk("hold_rdy", 8'(in_ready), 8'h00);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("hold_xfer_vld", 8'(out_valid), 8'h00);
      chk("hold_xfer_rdy", 8'(in_ready), 8'h01);

      // Divide by zero
`ifdef BPF_ALU_SEQ_DIV0_CHK_EN
      div0_exp = 8'h09;
`else
      div0_exp = 8'hFF;
`endif
      issue(16'h8009);
      issue(16'h4000);
      emit_chk("div0", div0_exp);
`ifdef BPF_ALU_SEQ_DIV0_CHK_EN
      chk("div0_err", 8'(err_div0), 8'h01);
`else
      chk("div0_err", 8'(err_div0), 8'h00);
`endif
      issue(16'h1001);
      issue(16'h8002);
      @(negedge clk);
`ifdef BPF_ALU_SEQ_DIV0_CHK_EN
      chk("div0_sticky", 8'(err_div0), 8'h01);
`else
      chk("div0_sticky", 8'(err_div0), 8'h00);
`endif

      // Asynchronous reset while in EMIT
      out_ready = 1'b0;
      issue(16'hA000);
      chk("arst_pre_vld", 8'(out_valid), 8'h01);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_vld", 8'(out_valid), 8'h00);
      chk("arst_rdy", 8'(in_ready), 8'h01);
      chk("arst_err", 8'(err_div0), 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      emit_chk("post_rst", 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bpf_alu_seq.md
# bpf_alu_seq

Instruction sequencer that drives the 8-bit ALU: the initiator side of the ALU's `i1`/`i2`/`op` → `o` interface. It accepts 16-bit BPF-style instruction words over a valid/ready handshake and holds accumulator A and index X. It issues one ALU operation per instruction, writes the result back to A, and emits A downstream on request. It sits between the instruction fetch path and the combinational ALU in the datapath.

## Interface
Parameters:
- `DATA_W`, 8, operand/result width; must equal the ALU width.
- `OP_W`, 4, ALU op-code width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  instruction word valid.
- `in_ready`  out  1  sequencer can accept an instruction.
- `in_insn`  in  16  instruction: [15:12] opcode, [11] src (0 = imm, 1 = X), [10:8] reserved, [7:0] imm.
- `alu_i1`  out  DATA_W  ALU operand 1 (always A).
- `alu_i2`  out  DATA_W  ALU operand 2 (imm or X).
- `alu_op`  out  OP_W  ALU op code.
- `alu_o`  in  DATA_W  ALU result (combinational from `alu_*`).
- `out_valid`  out  1  emitted A valid.
- `out_ready`  in  1  downstream accepts emitted value.
- `out_data`  out  DATA_W  emitted value.
- `err_div0`  out  1  sticky divide-by-zero flag.

## Operation
- Opcodes:
  - 0 NOP.
  - 1–7: ALU ops, encoded identically to ALU codes: add, sub, mul, div, and, or, not. The result goes to A.
  - 8 LDA (A ← imm or X).
  - 9 TAX (X ← A).
  - 10 EMIT.
  - 11–15 are treated as NOP.
- States:
  - IDLE: `in_ready`=1. On `in_valid`, latch insn. Go to EXEC for ALU ops, EMIT for opcode 10. LDA, TAX and NOP complete in this same accepting edge and stay in IDLE.
  - EXEC: drive `alu_op` = opcode, `alu_i1` = A, `alu_i2` = src ? X : imm. At the edge, A ← `alu_o` and go to IDLE.
  - EMIT: `out_valid`=1, `out_data`=A. Stay until `out_ready`=1, then go to IDLE.
- Outside EXEC, `alu_op`=0 and `alu_i1`/`alu_i2`=0. The ALU then outputs 0 and the value is ignored.
- Arithmetic is modulo 2^DATA_W. Wrap-around is silent: A=0xFF add 1 → 0x00, no flag. Product is truncated to 8 bits.
- For `not`, `alu_i2` is still driven, and the result is ~A.
- Reset state: A=0, X=0, state IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `alu_*`=0, `err_div0`=0.
- Reset asserted mid-operation aborts immediately. A pending EMIT is dropped and the in-flight result is discarded.

## Timing
- `in_ready` is a registered-state decode: 1 only in IDLE. No combinational path from `in_valid` to `in_ready`.
- ALU instruction: accepted at edge t, ALU driven during cycle t+1, A updated at edge t+1. `in_ready` returns at t+1. Sustained throughput is 1 ALU insn per 2 cycles.
- LDA/TAX/NOP: register updated at the accepting edge, 1 insn/cycle sustained.
- EMIT: `out_valid` rises the cycle after acceptance. `out_data` is held stable while `out_valid`=1 and `out_ready`=0. Transfer occurs on the edge where both are 1.
- An instruction following an ALU op or LDA sees the updated A, because write-back completes before re-acceptance.

## Configuration
- `BPF_ALU_SEQ_DIV0_CHK_EN` defined:
  - In EXEC with op 4 and `alu_i2`=0, A is left unchanged and `err_div0` is set.
  - `err_div0` stays set until reset.
- Not defined:
  - A ← `alu_o` unconditionally, including for div by 0.
  - `err_div0` is tied to 0.

## Structure
- Shared package `bpf_pkg`:
  - ALU op-code constants OP_ADD..OP_NOT (1..7), matching the ALU encoding.
  - Sequencer opcodes OPC_LDA=8, OPC_TAX=9, OPC_EMIT=10.
  - State enum IDLE/EXEC/EMIT.
  - Instruction field positions.
- One combinational sub-module, `bpf_insn_dec`: maps `in_insn` to {is_alu, is_lda, is_tax, is_emit, alu_op, use_x, imm}.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- Reset, then LDA imm 0x05, ADD imm 0x03, EMIT with `out_ready`=1 → `out_data`=0x08. `alu_op`=1 for exactly one cycle.
- LDA 0xFF, ADD 0x01, EMIT → 0x00 (wrap), `err_div0`=0. Then LDA 0x10, MUL 0x20, EMIT → 0x00 (truncated).
- LDA 0x07, TAX, LDA 0x2A, DIV src=X, EMIT → 0x06. Back-to-back `in_valid`: `in_ready` low exactly one cycle after the DIV.
- EMIT with `out_ready` held 0 for 5 cycles → `out_valid`=1 and `out_data` stable throughout, `in_ready`=0. Raise `out_ready` → one transfer, `in_ready`=1 next cycle.
- With macro defined: LDA 0x09, DIV imm 0, EMIT → 0x09, `err_div0`=1 and stays 1 after further ops. Without the macro, `err_div0` remains 0.
- Assert `rst_n`=0 asynchronously while in EMIT → `out_valid` drops without a clock edge. After release, EMIT → 0x00.
